cache_requester: RTL and testbench

Initiator-side front end for the L1/L2 data cache. Accepts one load or store at a time from the pipeline over a valid/ready handshake, drives the cache's single-cycle read/write strobes and samples its registered read_data/miss outputs. On a read miss it fetches the word from a backing-memory port and installs it in the cache. Stores are write-through to backing memory. It returns one response per request and keeps a saturating read-miss counter for the performance counter block.

---
 rtl/cache_requester_if.sv | 41 ++++
 rtl/cache_requester.sv | 129 ++++++++++++
 tb/tb_cache_requester.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_requester_if.sv
// Pipeline, cache and backing-memory signals of the cache requester.
interface cache_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        miss;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  // Requester side (the design).
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
           read_data, miss, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_rdata, mem_read, mem_write,
           addr, write_data, mem_req_valid, mem_req_write,
           mem_req_addr, mem_req_wdata
  );

  // Environment side: pipeline, cache and backing memory.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
           read_data, miss, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_rdata, mem_read, mem_write,
           addr, write_data, mem_req_valid, mem_req_write,
           mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_requester.sv
// Single-outstanding load/store front end for the data cache: hit path,
// read-miss fill and install, store write-through, saturating miss counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a pipeline request
// ISSUE   | cache read strobe (load) or write/allocate strobe (store)
// CHECK   | cache read_data/miss valid; hit -> RESP, miss -> FILL
// FILL    | memory read outstanding for the missed word
// INSTALL | write fetched word into the cache
// WTHRU   | store write-through to memory outstanding
// RESP    | response held until the pipeline takes it
module cache_requester #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_requester_if.master bus,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CHECK   = 3'd2,
    FILL    = 3'd3,
    INSTALL = 3'd4,
    WTHRU   = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode, purely from state and latched registers.
  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_write  = 1'b0;
    bus.addr           = addr_q;
    bus.write_data     = wdata_q;
    bus.mem_req_addr   = addr_q;
    bus.mem_req_wdata  = wdata_q;
    bus.resp_rdata     = rdata_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (wr_q) begin
          bus.mem_write = 1'b1;
          state_nxt     = WTHRU;
        end else begin
          bus.mem_read  = 1'b1;
          state_nxt     = CHECK;
        end
      end
      CHECK: begin
        state_nxt = bus.miss ? FILL : RESP;
      end
      FILL: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_resp_valid) state_nxt = INSTALL;
      end
      INSTALL: begin
        bus.mem_write  = 1'b1;
        bus.write_data = rdata_q;
        state_nxt      = RESP;
      end
      WTHRU: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        if (bus.mem_resp_valid) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, response data and the saturating load-miss counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        CHECK: begin
          if (!bus.miss) rdata_q <= bus.read_data;
          else if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
        end
        FILL: begin
          if (bus.mem_resp_valid) rdata_q <= bus.mem_resp_data;
        end
        WTHRU: begin
          if (bus.mem_resp_valid) rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Directed bench for cache_requester; the bench plays pipeline, cache and memory.
module tb_cache_requester;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] miss_count;
  int         n_run = 0;
  int         n_fail = 0;
  int         n_rd = 0;
  int         n_memreq = 0;
  int         n_resp = 0;

  cache_requester_if bus();

  cache_requester #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Activity monitors used by the scenarios.
  always @(posedge clk) begin
    if (bus.mem_read)      n_rd     <= n_rd + 1;
    if (bus.mem_req_valid) n_memreq <= n_memreq + 1;
    if (bus.resp_valid)    n_resp   <= n_resp + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one cycle after it is accepted (cycle 1).
  task automatic accept(input logic wr, input logic [63:0] a, input logic [63:0] d,
                        input logic keep_valid);
    int k;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.req_ready) begin
      n_run++; n_fail++;
      $display("FAIL accept_timeout: req_ready=%b want 1", bus.req_ready);
    end
    tick();
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_run++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_run++; if ({bus.mem_read, bus.mem_write, bus.mem_req_valid, bus.mem_req_write} !== 4'b0)
      begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {bus.mem_read, bus.mem_write, bus.mem_req_valid, bus.mem_req_write}); end
    n_run++; if (miss_count !== 2'd0) begin n_fail++; $display("FAIL rst_miss_count: got %0d want 0", miss_count); end
    n_run++; if (bus.resp_rdata !== 64'h0 || bus.addr !== 64'h0) begin n_fail++; $display("FAIL rst_data: rdata %h addr %h want 0", bus.resp_rdata, bus.addr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    int rd0, mr0;
    accept(1'b0, 64'h100, 64'h0, 1'b0);
    n_run++; if (bus.mem_read !== 1'b1 || bus.addr !== 64'h100) begin n_fail++; $display("FAIL miss_issue: mem_read %b addr %h want 1 100", bus.mem_read, bus.addr); end
    tick();
    bus.miss = 1'b1; bus.read_data = 64'hBAD;
    tick();
    bus.miss = 1'b0; bus.read_data = 64'h0;
    n_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0 || bus.mem_req_addr !== 64'h100)
      begin n_fail++; $display("FAIL miss_fill_req: v %b w %b a %h want 1 0 100", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
    n_run++; if (miss_count !== 2'd1) begin n_fail++; $display("FAIL miss_count_1: got %0d want 1", miss_count); end
    tick(); tick(); tick();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h1234;
    tick();
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'h0;
    n_run++; if (bus.mem_write !== 1'b1 || bus.addr !== 64'h100 || bus.write_data !== 64'h1234 || bus.mem_req_valid !== 1'b0)
      begin n_fail++; $display("FAIL miss_install: w %b a %h d %h rv %b want 1 100 1234 0", bus.mem_write, bus.addr, bus.write_data, bus.mem_req_valid); end
    tick();
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1234)
      begin n_fail++; $display("FAIL miss_resp: v %b d %h want 1 1234", bus.resp_valid, bus.resp_rdata); end
    tick();
    mr0 = n_memreq; rd0 = n_rd;
    accept(1'b0, 64'h100, 64'h0, 1'b0);
    tick();
    bus.miss = 1'b0; bus.read_data = 64'h1234;
    tick();
    bus.read_data = 64'h0;
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1234 || n_memreq != mr0 || n_rd != rd0 + 1)
      begin n_fail++; $display("FAIL repeat_hit: v %b d %h memreq %0d reads %0d want 1 1234 %0d %0d", bus.resp_valid, bus.resp_rdata, n_memreq, n_rd, mr0, rd0 + 1); end
    n_run++; if (miss_count !== 2'd1) begin n_fail++; $display("FAIL repeat_hit_count: got %0d want 1", miss_count); end
    tick();
  endtask

  task automatic test_store_load_hit();
    int rd0, mr0;
    accept(1'b1, 64'h40, 64'hDEADBEEF, 1'b0);
    n_run++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.addr !== 64'h40 || bus.write_data !== 64'hDEADBEEF)
      begin n_fail++; $display("FAIL store_issue: w %b r %b a %h d %h want 1 0 40 deadbeef", bus.mem_write, bus.mem_read, bus.addr, bus.write_data); end
    tick();
    n_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_wdata !== 64'hDEADBEEF)
      begin n_fail++; $display("FAIL store_wthru: v %b w %b d %h want 1 1 deadbeef", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_wdata); end
    tick(); tick();
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h0)
      begin n_fail++; $display("FAIL store_resp: v %b d %h want 1 0", bus.resp_valid, bus.resp_rdata); end
    tick();
    n_run++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL store_idle: req_ready %b want 1", bus.req_ready); end
    rd0 = n_rd; mr0 = n_memreq;
    accept(1'b0, 64'h40, 64'h0, 1'b0);
    n_run++; if (bus.mem_read !== 1'b1 || bus.addr !== 64'h40) begin n_fail++; $display("FAIL hit_issue: r %b a %h want 1 40", bus.mem_read, bus.addr); end
    tick();
    bus.miss = 1'b0; bus.read_data = 64'hDEADBEEF;
    n_run++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_early_resp: got %b want 0", bus.resp_valid); end
    tick();
    bus.read_data = 64'h0;
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'hDEADBEEF || n_rd != rd0 + 1 || n_memreq != mr0)
      begin n_fail++; $display("FAIL hit_resp: v %b d %h reads %0d memreq %0d want 1 deadbeef %0d %0d", bus.resp_valid, bus.resp_rdata, n_rd, n_memreq, rd0 + 1, mr0); end
    tick();
  endtask

  task automatic test_zero_latency();
    accept(1'b0, 64'h200, 64'h0, 1'b0);
    tick();
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h55AA;
    tick();
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'h0;
    n_run++; if (bus.mem_write !== 1'b1 || bus.write_data !== 64'h55AA || bus.resp_valid !== 1'b0)
      begin n_fail++; $display("FAIL zl_install: w %b d %h rv %b want 1 55aa 0", bus.mem_write, bus.write_data, bus.resp_valid); end
    tick();
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h55AA)
      begin n_fail++; $display("FAIL zl_resp: v %b d %h want 1 55aa", bus.resp_valid, bus.resp_rdata); end
    n_run++; if (miss_count !== 2'd2) begin n_fail++; $display("FAIL zl_count: got %0d want 2", miss_count); end
    tick();
  endtask

  task automatic test_backpressure();
    accept(1'b0, 64'h300, 64'h0, 1'b1);
    bus.req_write = 1'b1; bus.req_addr = 64'h308; bus.req_wdata = 64'h7;
    bus.resp_ready = 1'b0;
    tick();
    bus.miss = 1'b0; bus.read_data = 64'hCAFE;
    tick();
    bus.read_data = 64'h0;
    for (int i = 0; i < 4; i++) begin
      n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'hCAFE || bus.req_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d]: v %b d %h rdy %b want 1 cafe 0", i, bus.resp_valid, bus.resp_rdata, bus.req_ready); end
      tick();
    end
    bus.resp_ready = 1'b1;
    n_run++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0)
      begin n_fail++; $display("FAIL bp_handshake: v %b rdy %b want 1 0", bus.resp_valid, bus.req_ready); end
    tick();
    n_run++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_write !== 1'b0)
      begin n_fail++; $display("FAIL bp_idle: rdy %b v %b w %b want 1 0 0", bus.req_ready, bus.resp_valid, bus.mem_write); end
    tick();
    bus.req_valid = 1'b0;
    n_run++; if (bus.mem_write !== 1'b1 || bus.addr !== 64'h308 || bus.write_data !== 64'h7 || bus.req_ready !== 1'b0)
      begin n_fail++; $display("FAIL bp_next_accept: w %b a %h d %h rdy %b want 1 308 7 0", bus.mem_write, bus.addr, bus.write_data, bus.req_ready); end
    tick();
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    n_run++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h0)
      begin n_fail++; $display("FAIL bp_store_resp: v %b d %h want 1 0", bus.resp_valid, bus.resp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int resp0;
    accept(1'b0, 64'h500, 64'h0, 1'b0);
    tick();
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    n_run++; if (miss_count !== 2'd3) begin n_fail++; $display("FAIL mf_count_pre: got %0d want 3", miss_count); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_run++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b1 || miss_count !== 2'd0)
      begin n_fail++; $display("FAIL mf_async: rv %b rdy %b cnt %0d want 0 1 0", bus.mem_req_valid, bus.req_ready, miss_count); end
    #3 rst_n = 1'b1;
    resp0 = n_resp;
    tick();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'h99;
    tick();
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'h0;
    tick(); tick(); tick();
    n_run++; if (n_resp != resp0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 64'h0)
      begin n_fail++; $display("FAIL mf_no_resp: resp %0d rdy %b d %h want %0d 1 0", n_resp, bus.req_ready, bus.resp_rdata, resp0); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [63:0] a;
    for (int i = 0; i < 5; i++) begin
      a = 64'h1000 + 64'(i * 8);
      accept(1'b0, a, 64'h0, 1'b0);
      tick();
      bus.miss = 1'b1;
      tick();
      bus.miss = 1'b0;
      n_run++; if (miss_count !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, miss_count, exp_cnt[i]); end
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'hA0 + 64'(i);
      tick();
      bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'h0;
      tick();
      n_run++; if (bus.resp_rdata !== 64'hA0 + 64'(i)) begin n_fail++; $display("FAIL sat_rdata[%0d]: got %h want %h", i, bus.resp_rdata, 64'hA0 + 64'(i)); end
      tick();
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 64'hFF;
    tick();
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 64'h0;
    tick();
    n_run++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_req_valid !== 1'b0 || miss_count !== 2'd3)
      begin n_fail++; $display("FAIL stray_ack: rdy %b v %b w %b rv %b cnt %0d want 1 0 0 0 3", bus.req_ready, bus.resp_valid, bus.mem_write, bus.mem_req_valid, miss_count); end
    n_run++; if (bus.resp_rdata !== 64'hA4) begin n_fail++; $display("FAIL stray_rdata: got %h want a4", bus.resp_rdata); end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = 64'h0;
    bus.req_wdata      = 64'h0;
    bus.resp_ready     = 1'b1;
    bus.read_data      = 64'h0;
    bus.miss           = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 64'h0;
    test_reset();
    test_cold_miss();
    test_store_load_hit();
    test_zero_latency();
    test_backpressure();
    test_reset_mid_fill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
